// File: rtl/id_fwd_if.sv
// id_fwd_if: bundles the decode-side inputs and ID/EX-side outputs of id_fwd_stage.
//   master : decoder/forwarding/control producers (drive in_*, src_*, rf_data, imm_i,
//            fwd_*, stall_i, flush_i; observe stall_req_o, out_*, stall_cnt)
//   slave  : id_fwd_stage itself (the reverse directions)
interface id_fwd_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CTRL_W  = 11
);
  localparam int unsigned CNT_W = 16;

  logic                       in_valid;
  logic [CTRL_W-1:0]          in_ctrl;
  logic                       in_wreg;
  logic [ADDR_W-1:0]          in_waddr;
  logic [NUM_SRC-1:0]         src_en;
  logic [NUM_SRC*ADDR_W-1:0]  src_addr;
  logic [NUM_SRC*DATA_W-1:0]  rf_data;
  logic [DATA_W-1:0]          imm_i;
  logic [NUM_FWD-1:0]         fwd_wreg;
  logic [NUM_FWD*ADDR_W-1:0]  fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata;
  logic [NUM_FWD-1:0]         fwd_pend;
  logic                       stall_i;
  logic                       flush_i;

  logic                       stall_req_o;
  logic                       out_valid;
  logic [CTRL_W-1:0]          out_ctrl;
  logic                       out_wreg;
  logic [ADDR_W-1:0]          out_waddr;
  logic [NUM_SRC*DATA_W-1:0]  out_src;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output in_valid, in_ctrl, in_wreg, in_waddr, src_en, src_addr, rf_data, imm_i,
           fwd_wreg, fwd_waddr, fwd_wdata, fwd_pend, stall_i, flush_i,
    input  stall_req_o, out_valid, out_ctrl, out_wreg, out_waddr, out_src, stall_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_wreg, in_waddr, src_en, src_addr, rf_data, imm_i,
           fwd_wreg, fwd_waddr, fwd_wdata, fwd_pend, stall_i, flush_i,
    output stall_req_o, out_valid, out_ctrl, out_wreg, out_waddr, out_src, stall_cnt
  );
endinterface

// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode-stage operand selection with forwarding, load-use hazard
// detection and the ID/EX pipeline register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : id_fwd_if.slave -- decoded instruction, source addresses, regfile data,
//              immediate, forwarding stages (index 0 youngest), stall_i/flush_i in;
//              stall_req_o (combinational), registered out_* and stall_cnt out
module id_fwd_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CTRL_W  = 11
) (
  input logic       clk,
  input logic       rst,
  id_fwd_if.slave   bus
);
  localparam int unsigned CNT_W = 16;

  logic [NUM_SRC-1:0]         hit_c;
  logic [NUM_SRC-1:0]         pend_c;
  logic [NUM_SRC*DATA_W-1:0]  fval_c;
  logic [NUM_SRC*DATA_W-1:0]  opnd_c;
  logic                       hazard_c;
  logic                       stall_req_c;

  logic                       valid_q;
  logic [CTRL_W-1:0]          ctrl_q;
  logic                       wreg_q;
  logic [ADDR_W-1:0]          waddr_q;
  logic [NUM_SRC*DATA_W-1:0]  src_q;
  logic [CNT_W-1:0]           cnt_q;

  // Operand select and load-use detection per source
  always_comb begin
    hit_c    = '0;
    pend_c   = '0;
    fval_c   = '0;
    opnd_c   = '0;
    hazard_c = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Walk oldest to youngest so the youngest matching stage is left standing
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (bus.fwd_wreg[k] &&
            (bus.fwd_waddr[k*ADDR_W +: ADDR_W] == bus.src_addr[i*ADDR_W +: ADDR_W])) begin
          hit_c[i]                  = 1'b1;
          pend_c[i]                 = bus.fwd_pend[k];
          fval_c[i*DATA_W +: DATA_W] = bus.fwd_wdata[k*DATA_W +: DATA_W];
        end
      end
      if (!bus.src_en[i]) begin
        // Only the last source slot carries the immediate
        opnd_c[i*DATA_W +: DATA_W] = (i == NUM_SRC - 1) ? bus.imm_i : '0;
      end else if (bus.src_addr[i*ADDR_W +: ADDR_W] == '0) begin
        opnd_c[i*DATA_W +: DATA_W] = '0;
      end else if (hit_c[i]) begin
        opnd_c[i*DATA_W +: DATA_W] = fval_c[i*DATA_W +: DATA_W];
        if (pend_c[i] && bus.in_valid) begin
          hazard_c = 1'b1;
        end
      end else begin
        opnd_c[i*DATA_W +: DATA_W] = bus.rf_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign stall_req_c = hazard_c | (bus.stall_i & bus.in_valid);

  // ID/EX register: flush > hold > hazard bubble > capture; stall counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      waddr_q <= '0;
      ctrl_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.flush_i || (!bus.stall_i && hazard_c)) begin
        valid_q <= 1'b0;
        wreg_q  <= 1'b0;
        waddr_q <= '0;
        ctrl_q  <= '0;
        src_q   <= '0;
      end else if (!bus.stall_i) begin
        valid_q <= bus.in_valid;
        wreg_q  <= bus.in_wreg & bus.in_valid;
        waddr_q <= bus.in_waddr;
        ctrl_q  <= bus.in_ctrl;
        src_q   <= opnd_c;
      end
      if (stall_req_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_req_o = stall_req_c;
  assign bus.out_valid   = valid_q;
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_wreg    = wreg_q;
  assign bus.out_waddr   = waddr_q;
  assign bus.out_src     = src_q;
  assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_id_fwd_stage.sv
// tb_id_fwd_stage: directed stimulus with a scoreboard queue; a negedge monitor
// pops expectations tagged with the cycle they belong to and compares.
module tb_id_fwd_stage;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned CTRL_W  = 11;

  typedef struct packed {
    logic        valid;
    logic [10:0] ctrl;
    logic        wreg;
    logic [4:0]  waddr;
    logic [1:0]  en;
    logic [4:0]  sa0, sa1;
    logic [31:0] rf0, rf1, imm;
    logic [1:0]  fw;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;
    logic [1:0]  fp;
    logic        st, fl;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic [4:0]  waddr;
    logic [10:0] ctrl;
    logic [31:0] s0, s1;
  } exp_t;

  typedef struct {
    int          tag;
    bit          is_out;
    logic        req;
    exp_t        e;
    logic [15:0] cnt;
    string       nm;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mcnt = 16'd0;
  item_t q[$];
  item_t mit;

  id_fwd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
              .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W)) bus ();

  id_fwd_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
                 .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      mit = q.pop_front();
      if (mit.tag < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d skipped at %0d", mit.nm, mit.tag, cyc);
      end else if (!mit.is_out) begin
        cmp({mit.nm, ".stall_req"}, 32'(bus.stall_req_o), 32'(mit.req));
      end else begin
        cmp({mit.nm, ".valid"}, 32'(bus.out_valid), 32'(mit.e.valid));
        cmp({mit.nm, ".wreg"},  32'(bus.out_wreg),  32'(mit.e.wreg));
        cmp({mit.nm, ".waddr"}, 32'(bus.out_waddr), 32'(mit.e.waddr));
        cmp({mit.nm, ".ctrl"},  32'(bus.out_ctrl),  32'(mit.e.ctrl));
        cmp({mit.nm, ".src0"},  bus.out_src[31:0],  mit.e.s0);
        cmp({mit.nm, ".src1"},  bus.out_src[63:32], mit.e.s1);
        cmp({mit.nm, ".cnt"},   32'(bus.stall_cnt), 32'(mit.cnt));
      end
    end
  end

  function automatic exp_t mk(input logic v, input logic w, input logic [4:0] a,
                              input logic [10:0] c, input logic [31:0] s0,
                              input logic [31:0] s1);
    exp_t e;
    e.valid = v; e.wreg = w; e.waddr = a; e.ctrl = c; e.s0 = s0; e.s1 = s1;
    return e;
  endfunction

  task automatic apply(input vec_t v);
    bus.in_valid  = v.valid;
    bus.in_ctrl   = v.ctrl;
    bus.in_wreg   = v.wreg;
    bus.in_waddr  = v.waddr;
    bus.src_en    = v.en;
    bus.src_addr  = {v.sa1, v.sa0};
    bus.rf_data   = {v.rf1, v.rf0};
    bus.imm_i     = v.imm;
    bus.fwd_wreg  = v.fw;
    bus.fwd_waddr = {v.fa1, v.fa0};
    bus.fwd_wdata = {v.fd1, v.fd0};
    bus.fwd_pend  = v.fp;
    bus.stall_i   = v.st;
    bus.flush_i   = v.fl;
  endtask

  // Drive one cycle; expected stall_req checks now, expected outputs after the edge
  task automatic issue(input string nm, input vec_t v, input logic req,
                       input exp_t e, input bit chk);
    item_t it;
    apply(v);
    if (req && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    if (chk) begin
      it.tag = cyc;     it.is_out = 1'b0; it.req = req; it.e = '0; it.cnt = '0; it.nm = nm;
      q.push_back(it);
      it.tag = cyc + 1; it.is_out = 1'b1; it.e = e; it.cnt = mcnt;
      q.push_back(it);
    end
    @(posedge clk); #1;
  endtask

  vec_t v, i1, i2, d1, d2;
  exp_t z, e_i1, e_i2, e_d2;
  item_t rit;

  initial begin
    z = '0;
    // Reset with busy random inputs, stall request forced on
    rst = 1'b1;
    v = vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    v.valid = 1'b1; v.st = 1'b1; v.fl = 1'b0;
    apply(v);
    @(posedge clk); @(posedge clk); #1;
    rit.tag = cyc; rit.is_out = 1'b1; rit.req = 1'b0; rit.e = z; rit.cnt = 16'd0; rit.nm = "reset";
    q.push_back(rit);
    rst = 1'b0;
    apply('0);
    @(posedge clk); #1;

    // Youngest forward wins; src1 disabled takes immediate
    v = '0; v.valid = 1; v.ctrl = 11'h155; v.wreg = 1; v.waddr = 7; v.en = 2'b01;
    v.sa0 = 1; v.sa1 = 3; v.rf0 = 32'h99; v.rf1 = 32'h77; v.imm = 32'h21;
    v.fw = 2'b11; v.fa0 = 1; v.fd0 = 32'h16; v.fa1 = 1; v.fd1 = 32'h0B;
    issue("fwd_young", v, 0, mk(1, 1, 7, 11'h155, 32'h16, 32'h21), 1);

    // $0 never forwarded; src1 forwarded from the older stage
    v = '0; v.valid = 1; v.ctrl = 11'h0AA; v.wreg = 0; v.waddr = 3; v.en = 2'b11;
    v.sa0 = 0; v.sa1 = 2; v.rf0 = 32'h5; v.rf1 = 32'h1234;
    v.fw = 2'b11; v.fa0 = 0; v.fd0 = 32'hFFFF_FFFF; v.fa1 = 2; v.fd1 = 32'h5555;
    issue("zero_reg", v, 0, mk(1, 0, 3, 11'h0AA, 32'h0, 32'h5555), 1);

    // Invalid instruction never writes
    v = '0; v.valid = 0; v.ctrl = 11'h003; v.wreg = 1; v.waddr = 9; v.imm = 32'h44;
    issue("invalid_wreg", v, 0, mk(0, 0, 9, 11'h003, 32'h0, 32'h44), 1);

    // Load-use: youngest match pending -> bubble, then resolved via fwd1
    d1 = '0; d1.valid = 1; d1.ctrl = 11'h0F0; d1.wreg = 1; d1.waddr = 6; d1.en = 2'b10;
    d1.sa1 = 4; d1.imm = 32'h10; d1.fw = 2'b11; d1.fa0 = 4; d1.fd0 = 32'hDEAD;
    d1.fa1 = 4; d1.fd1 = 32'h1111; d1.fp = 2'b01;
    issue("hazard", d1, 1, z, 1);
    d2 = d1; d2.fw = 2'b10; d2.fa0 = 0; d2.fd0 = 0; d2.fd1 = 32'hABCD; d2.fp = 2'b00;
    e_d2 = mk(1, 1, 6, 11'h0F0, 32'h0, 32'hABCD);
    issue("resolved", d2, 0, e_d2, 1);

    // Pending on an older, non-winning match is ignored
    v = '0; v.valid = 1; v.ctrl = 11'h001; v.wreg = 1; v.waddr = 5; v.en = 2'b01;
    v.sa0 = 5; v.rf0 = 32'hEEEE; v.imm = 32'h7;
    v.fw = 2'b11; v.fa0 = 5; v.fd0 = 32'hC; v.fa1 = 5; v.fd1 = 32'hBAD; v.fp = 2'b10;
    issue("old_pend", v, 0, mk(1, 1, 5, 11'h001, 32'hC, 32'h7), 1);

    // Pending match without in_valid: no hazard; enabled src at $0 reads 0
    v = '0; v.valid = 0; v.ctrl = 11'h7FF; v.wreg = 1; v.waddr = 5'h1F; v.en = 2'b11;
    v.sa0 = 4; v.sa1 = 0; v.rf1 = 32'h22; v.fw = 2'b01; v.fa0 = 4; v.fd0 = 32'h3; v.fp = 2'b01;
    issue("pend_invalid", v, 0, mk(0, 0, 5'h1F, 11'h7FF, 32'h3, 32'h0), 1);

    // Pending match on a disabled source: no hazard
    v = '0; v.valid = 1; v.ctrl = 11'h100; v.wreg = 0; v.waddr = 2; v.en = 2'b00;
    v.sa0 = 4; v.fw = 2'b01; v.fa0 = 4; v.fd0 = 32'h9; v.fp = 2'b01; v.imm = 32'h33;
    issue("pend_disabled", v, 0, mk(1, 0, 2, 11'h100, 32'h0, 32'h33), 1);

    // Hold / flush sequence
    i1 = '0; i1.valid = 1; i1.ctrl = 11'h011; i1.wreg = 1; i1.waddr = 10; i1.en = 2'b01;
    i1.sa0 = 3; i1.rf0 = 32'h3333; i1.imm = 32'h1;
    e_i1 = mk(1, 1, 10, 11'h011, 32'h3333, 32'h1);
    issue("i1", i1, 0, e_i1, 1);
    i2 = '0; i2.valid = 1; i2.ctrl = 11'h022; i2.wreg = 1; i2.waddr = 11; i2.en = 2'b11;
    i2.sa0 = 8; i2.sa1 = 9; i2.rf0 = 32'h88; i2.rf1 = 32'h99;
    e_i2 = mk(1, 1, 11, 11'h022, 32'h88, 32'h99);
    v = i2; v.st = 1;
    issue("hold_i1", v, 1, e_i1, 1);
    v = i2; v.st = 1; v.fl = 1;
    issue("flush_over_stall", v, 1, z, 1);
    v = i2; v.st = 1;
    issue("hold_bubble", v, 1, z, 1);
    issue("i2", i2, 0, e_i2, 1);
    v = i2; v.valid = 0; v.st = 1;
    issue("hold_novalid", v, 0, e_i2, 1);
    v = d1; v.st = 1;
    issue("stall_over_hazard", v, 1, e_i2, 1);
    v = d1; v.fl = 1;
    issue("flush_hazard", v, 1, z, 1);

    // Saturation of the stall counter
    begin
      int sat_i;
      sat_i = 65535 - int'(mcnt) - 1;
      for (int i = 0; i < 70000; i++) begin
        issue("sat", d1, 1, z, (i == 0) || (i == sat_i) || (i == sat_i + 1) || (i == 69999));
      end
    end
    issue("after_sat", d2, 0, e_d2, 1);

    apply('0);
    repeat (3) begin @(posedge clk); #1; end
    cmp("drain_queue", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_fwd_stage.md
Name: id_fwd_stage

Overview:
- Parametrised decode-stage operand unit and ID/EX pipeline register.
- Sits between the instruction decoder and the EX stage.
- Selects each source operand from regfile data, the immediate, or any of NUM_FWD forwarding stages (youngest first).
- Detects load-use hazards, raises a stall request and inserts bubbles; supports downstream hold and flush; keeps a stall-cycle counter.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction
NUM_FWD, 2, forwarding stages; index 0 = youngest (EX), NUM_FWD-1 = oldest
CTRL_W, 11, width of opaque decoder control bundle (alusel+aluop)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  decoded instruction present
in_ctrl  in  CTRL_W  control bundle, passed through
in_wreg  in  1  instruction writes a register
in_waddr  in  ADDR_W  destination register
src_en  in  NUM_SRC  bit i: source i reads a register
src_addr  in  NUM_SRC*ADDR_W  source register addresses, src i at [i*ADDR_W +: ADDR_W]
rf_data  in  NUM_SRC*DATA_W  regfile read data, same packing
imm_i  in  DATA_W  extended immediate
fwd_wreg  in  NUM_FWD  stage k writes a register
fwd_waddr  in  NUM_FWD*ADDR_W  stage k destination
fwd_wdata  in  NUM_FWD*DATA_W  stage k result
fwd_pend  in  NUM_FWD  stage k result not yet available (load in flight)
stall_i  in  1  downstream hold
flush_i  in  1  discard ID/EX contents
stall_req_o  out  1  upstream must hold IF/ID (combinational)
out_valid  out  1  registered valid
out_ctrl  out  CTRL_W  registered control
out_wreg  out  1  registered write enable
out_waddr  out  ADDR_W  registered destination
out_src  out  NUM_SRC*DATA_W  registered operands
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Operand select (combinational), per source i:
  - src_en[i]=0: operand = imm_i if i==NUM_SRC-1, else 0.
  - src_en[i]=1 and src_addr[i]==0: operand = 0. Register 0 is never forwarded.
  - Otherwise the lowest k with fwd_wreg[k]=1 and fwd_waddr[k]==src_addr[i] wins; operand = fwd_wdata[k].
  - No match: operand = rf_data[i].
- Hazard: asserted when in_valid=1 and some enabled source's winning match k has fwd_pend[k]=1. fwd_pend on a non-winning (older) match is ignored.
- stall_req_o = hazard | (stall_i & in_valid).
- Register update each clk rising edge, priority order:
  1. rst: out_valid=0, out_wreg=0, out_waddr=0, out_ctrl=0, out_src=0, stall_cnt=0.
  2. flush_i: bubble (out_valid=0, out_wreg=0, out_waddr=0, out_ctrl=0, out_src=0). Flush beats stall_i and hazard.
  3. stall_i: hold all outputs.
  4. hazard: bubble.
  5. Otherwise: out_valid=in_valid, out_wreg=in_wreg&in_valid, capture ctrl/waddr/operands.
- Latency: 1 cycle from ID inputs to out_*.
- stall_cnt: +1 on each clock with stall_req_o=1 and rst=0; saturates at 0xFFFF. Not cleared by flush.
- A bubble never writes a register: out_wreg=0 whenever out_valid=0.
- Hazard resolution: once fwd_pend clears, or the producer moves to an older non-pending stage, the same held instruction issues on the next edge with the forwarded value.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all outputs 0, stall_cnt=0.
- src0=$1, src1 disabled, imm_i=0x21, fwd0 writes $1=0x16, fwd1 writes $1=0x0B -> next cycle out_src0=0x16, out_src1=0x21, out_valid=1.
- src0=$0, fwd0 writes $0=0xFFFF_FFFF, rf_data0=0x5 -> out_src0=0.
- src1=$4, fwd0 writes $4 with fwd_pend0=1 for 1 cycle, then producer appears in fwd1 with 0xABCD, pend=0 -> stall_req_o=1 for one cycle, one bubble out, then out_src1=0xABCD, stall_cnt=1.
- Valid instruction with stall_i=1 and flush_i=1 in the same cycle -> out_valid=0, out_wreg=0 (flush wins). Next cycle stall_i=1 only -> outputs held.
- Hazard forced 70000 cycles -> stall_cnt saturates at 0xFFFF, no wrap.
